// File: rtl/u_dmem_pkg.sv
// Shared types for the data-side write buffer.
// Entry layout, FSM states and lane geometry.
package u_dmem_pkg;

  localparam int LANES      = 4;
  localparam int OFF_W      = 2;
  localparam int MAX_ADDR_W = 32;
  localparam int WADDR_W    = MAX_ADDR_W - OFF_W;

  typedef struct packed {
    logic [WADDR_W-1:0] addr;
    logic [31:0]        data;
    logic [LANES-1:0]   be;
  } wbuf_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    WR_REQ,
    RD_REQ
  } dmem_state_e;

endpackage

// File: rtl/u_wbuf_fifo.sv
// Posted-store FIFO with count, full/empty and a parallel
// word-address match across all live entries.
module u_wbuf_fifo
  import u_dmem_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  wbuf_entry_t        push_entry,
  input  logic               pop,
  input  logic [WADDR_W-1:0] match_addr,
  output wbuf_entry_t        head,
  output logic [CNT_W-1:0]   count,
  output logic               full,
  output logic               empty,
  output logic               match
);

  localparam int PTR_W = $clog2(DEPTH);

  wbuf_entry_t      mem_q [DEPTH];
  wbuf_entry_t      mem_d [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem_q[rptr_q];
  assign count   = count_q;

  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_push) begin
      mem_d[wptr_q] = push_entry;
      wptr_d        = wptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rptr_d = rptr_q + PTR_W'(1);
    end
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // A slot is live when its distance from the read pointer is below count.
  always_comb begin
    logic [PTR_W-1:0] off;
    off   = '0;
    match = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      off = PTR_W'(i) - rptr_q;
      if ((CNT_W'(off) < count_q) &&
          (mem_q[i].addr == match_addr)) begin
        match = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q   <= '{default: '0};
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/u_dmem_wbuf.sv
// CPU data port with posted write buffer and blocking loads.
// Define WBUF_LOAD_BYPASS_EN to let loads pass non-matching stores.
module u_dmem_wbuf
  import u_dmem_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic              i_sys_clock,
  input  logic              i_sys_reset,
  input  logic [ADDR_W-1:0] i_u_dmem_addr,
  input  logic [31:0]       i_u_dmem_wdata,
  input  logic              i_u_dmem_word,
  input  logic              i_u_dmem_wr,
  input  logic              i_u_dmem_rd,
  output logic [31:0]       o_u_dmem_rdata,
  output logic              o_u_dmem_stall,
  output logic              o_u_dmem_empty,
  output logic              o_u_dmem_mem_req,
  output logic              o_u_dmem_mem_we,
  output logic [ADDR_W-1:0] o_u_dmem_mem_addr,
  output logic [31:0]       o_u_dmem_mem_wdata,
  output logic [3:0]        o_u_dmem_mem_be,
  input  logic              i_u_dmem_mem_ack,
  input  logic [31:0]       i_u_dmem_mem_rdata
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  dmem_state_e        state_q, state_d;
  logic               req_q, req_d;
  logic               rvalid_q, rvalid_d;
  logic [31:0]        rdata_q, rdata_d;
  wbuf_entry_t        push_entry, head;
  logic [WADDR_W-1:0] cpu_waddr;
  logic [CNT_W-1:0]   count;
  logic               full, fifo_empty, match;
  logic               push, pop, ack;
  logic               load_pend, load_ok;
  logic [7:0]         rd_lane;

  always_comb begin
    cpu_waddr = '0;
    cpu_waddr[ADDR_W-OFF_W-1:0] =
      i_u_dmem_addr[ADDR_W-1:OFF_W];
  end

  always_comb begin
    push_entry.addr = cpu_waddr;
    if (i_u_dmem_word) begin
      push_entry.data = i_u_dmem_wdata;
      push_entry.be   = 4'hF;
    end else begin
      push_entry.data = {4{i_u_dmem_wdata[7:0]}};
      push_entry.be   = LANES'(1) << i_u_dmem_addr[1:0];
    end
  end

  assign ack  = req_q & i_u_dmem_mem_ack;
  assign push = i_u_dmem_wr & ~full;
  assign pop  = (state_q == WR_REQ) & ack;

  u_wbuf_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (i_sys_clock),
    .rst_n      (i_sys_reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .match_addr (cpu_waddr),
    .head       (head),
    .count      (count),
    .full       (full),
    .empty      (fifo_empty),
    .match      (match)
  );

  assign load_pend = i_u_dmem_rd & ~rvalid_q;

`ifdef WBUF_LOAD_BYPASS_EN
  assign load_ok = ~match;
`else
  assign load_ok = fifo_empty & ~match;
`endif

  assign rd_lane =
    i_u_dmem_mem_rdata[{i_u_dmem_addr[1:0], 3'b000} +: 8];

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    rvalid_d = 1'b0;
    rdata_d  = rdata_q;
    unique case (state_q)
      IDLE: begin
        req_d = 1'b0;
        if (load_pend && load_ok) begin
          state_d = RD_REQ;
        end else if (!fifo_empty) begin
          state_d = WR_REQ;
        end
      end
      WR_REQ: begin
        req_d = ~ack;
        if (ack) begin
          state_d = IDLE;
        end
      end
      RD_REQ: begin
        req_d = ~ack;
        if (ack) begin
          state_d  = IDLE;
          rvalid_d = 1'b1;
          rdata_d  = i_u_dmem_word ? i_u_dmem_mem_rdata
                                   : {24'h0, rd_lane};
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_sys_clock or negedge i_sys_reset) begin
    if (!i_sys_reset) begin
      state_q  <= IDLE;
      req_q    <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  always_comb begin
    o_u_dmem_mem_addr  = '0;
    o_u_dmem_mem_wdata = '0;
    o_u_dmem_mem_be    = '0;
    unique case (state_q)
      WR_REQ: begin
        o_u_dmem_mem_addr =
          {head.addr[ADDR_W-OFF_W-1:0], {OFF_W{1'b0}}};
        o_u_dmem_mem_wdata = head.data;
        o_u_dmem_mem_be    = head.be;
      end
      RD_REQ: begin
        o_u_dmem_mem_addr =
          {i_u_dmem_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        o_u_dmem_mem_be = 4'hF;
      end
      default: ;
    endcase
  end

  assign o_u_dmem_mem_req = req_q;
  assign o_u_dmem_mem_we  = (state_q == WR_REQ);
  assign o_u_dmem_rdata   = rdata_q;
  assign o_u_dmem_empty   = fifo_empty & (state_q == IDLE);
  assign o_u_dmem_stall   = (i_u_dmem_wr & full) |
                            (i_u_dmem_rd & ~rvalid_q);

  a_rd_wr: assert property (
    @(posedge i_sys_clock) disable iff (!i_sys_reset)
    !(i_u_dmem_rd && i_u_dmem_wr));

  a_align: assert property (
    @(posedge i_sys_clock) disable iff (!i_sys_reset)
    ((i_u_dmem_rd || i_u_dmem_wr) && i_u_dmem_word)
      |-> (i_u_dmem_addr[1:0] == 2'b00));

endmodule

// File: tb/tb_u_dmem_wbuf.sv
// Directed bench for u_dmem_wbuf: bus slave with memory model,
// scoreboard queues for bus writes and load results.
module tb_u_dmem_wbuf;

  logic        clk, rst_n;
  logic [31:0] addr, wdata;
  logic        word, wr, rd;
  logic [31:0] rdata;
  logic        stall, empty;
  logic        mreq, mwe;
  logic [31:0] maddr, mwdata;
  logic [3:0]  mbe;
  logic        mack;
  logic [31:0] mrdata;

  int errors = 0;
  int checks = 0;
  int hold = 0;
  int ack_dly = 0;
  int rd_wq_size = 0;
  bit mon_en = 0;
  bit stall_seen = 0;

  logic [67:0] wq [$];
  logic [31:0] rq [$];
  logic [31:0] mem [int unsigned];

  u_dmem_wbuf #(.DEPTH(4), .ADDR_W(32)) dut (
    .i_sys_clock        (clk),
    .i_sys_reset        (rst_n),
    .i_u_dmem_addr      (addr),
    .i_u_dmem_wdata     (wdata),
    .i_u_dmem_word      (word),
    .i_u_dmem_wr        (wr),
    .i_u_dmem_rd        (rd),
    .o_u_dmem_rdata     (rdata),
    .o_u_dmem_stall     (stall),
    .o_u_dmem_empty     (empty),
    .o_u_dmem_mem_req   (mreq),
    .o_u_dmem_mem_we    (mwe),
    .o_u_dmem_mem_addr  (maddr),
    .o_u_dmem_mem_wdata (mwdata),
    .o_u_dmem_mem_be    (mbe),
    .i_u_dmem_mem_ack   (mack),
    .i_u_dmem_mem_rdata (mrdata)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mon_en && stall) stall_seen <= 1'b1;
  end

  task automatic chk(input string tag,
                     input logic [67:0] obs,
                     input logic [67:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Bus slave: acks ack_dly cycles after req is seen, unless held.
  initial begin : bus_slave
    int          wait_cnt;
    logic [67:0] exp;
    logic [31:0] w;
    int unsigned k;
    wait_cnt = 0;
    mack = 0;
    mrdata = 0;
    forever begin
      @(posedge clk); #1;
      mack = 0;
      if (!rst_n || !mreq || hold != 0) begin
        wait_cnt = 0;
      end else if (wait_cnt < ack_dly) begin
        wait_cnt++;
      end else begin
        wait_cnt = 0;
        mack = 1;
        k = maddr >> 2;
        if (mwe) begin
          exp = (wq.size() != 0) ? wq.pop_front() : '1;
          chk("bus_wr", {maddr, mbe, mwdata}, exp);
          w = mem.exists(k) ? mem[k] : 32'h0;
          for (int b = 0; b < 4; b++)
            if (mbe[b]) w[8*b +: 8] = mwdata[8*b +: 8];
          mem[k] = w;
        end else begin
          rd_wq_size = wq.size();
          mrdata = mem.exists(k) ? mem[k] : 32'h0;
        end
      end
    end
  end

  // Called at +2 after an edge; returns at +2 after the accepting edge.
  task automatic store(input logic [31:0] a,
                       input logic [31:0] d,
                       input logic w,
                       output int n);
    logic [3:0]  be;
    logic [31:0] dd;
    be = w ? 4'hF : (4'b0001 << a[1:0]);
    dd = w ? d : {4{d[7:0]}};
    wq.push_back({a & ~32'h3, be, dd});
    addr = a; wdata = d; word = w; wr = 1;
    n = 0;
    #1;
    while (stall && n < 200) begin
      @(posedge clk); #3; n++;
    end
    if (n >= 200) chk("store_timeout", stall, 0);
    @(posedge clk); #2;
    wr = 0;
  endtask

  task automatic load_start(input logic [31:0] a,
                            input logic w,
                            input logic [31:0] exp);
    addr = a; word = w; rd = 1;
    rq.push_back(exp);
  endtask

  task automatic load_wait(input string tag,
                           input bit keep,
                           output int n);
    logic [31:0] exp;
    n = 0;
    #1;
    while (stall && n < 400) begin
      @(posedge clk); #3; n++;
    end
    if (n >= 400) chk({tag, "_timeout"}, stall, 0);
    exp = (rq.size() != 0) ? rq.pop_front() : 32'hDEADBEEF;
    chk(tag, rdata, exp);
    if (!keep) rd = 0;
    @(posedge clk); #2;
  endtask

  task automatic wait_empty(input string tag);
    int n;
    n = 0;
    #1;
    while (!empty && n < 200) begin
      @(posedge clk); #3; n++;
    end
    chk(tag, empty, 1);
    @(posedge clk); #2;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n, sc, reqcnt;
    rst_n = 0; addr = 0; wdata = 0; word = 0; wr = 0; rd = 0;
    repeat (3) @(posedge clk);
    #3;
    chk("rst_rdata", rdata, 0);
    chk("rst_stall", stall, 0);
    chk("rst_empty", empty, 1);
    chk("rst_req", mreq, 0);
    chk("rst_bus", {mwe, mbe, maddr, mwdata}, 0);
    #9;
    rst_n = 1;
    @(posedge clk); #2;

    // 1: word store, ack two cycles after req
    ack_dly = 2;
    stall_seen = 0; mon_en = 1;
    store(32'h3E8, 32'h12341E61, 1, n);
    chk("t1_accept", n, 0);
    wait_empty("t1_empty");
    mon_en = 0;
    chk("t1_stall", stall_seen, 0);
    chk("t1_drained", wq.size(), 0);

    // 2: byte store then word load after drain
    ack_dly = 1;
    store(32'h3E9, 32'h0000003A, 0, n);
    load_start(32'h3E8, 1, 32'h12343A61);
    load_wait("t2_load", 0, n);
    chk("t2_stalled", n > 0, 1);
    chk("t2_after_drain", rd_wq_size, 0);

    // 3: five stores with ack withheld
    hold = 1; ack_dly = 0; sc = 0;
    for (int i = 0; i < 4; i++) begin
      store(32'h10 + 4*i, 32'h55550001 + i, 1, n);
      sc += n;
    end
    chk("t3_no_stall4", sc, 0);
    wq.push_back({32'h20, 4'hF, 32'h55550005});
    addr = 32'h20; wdata = 32'h55550005; word = 1; wr = 1;
    #1;
    sc = 0;
    for (int i = 0; i < 3; i++) begin
      if (stall) sc++;
      @(posedge clk); #3;
    end
    chk("t3_full_stall", sc, 3);
    hold = 0;
    n = 0;
    while (stall && n < 50) begin
      @(posedge clk); #3; n++;
    end
    chk("t3_accept", stall, 0);
    chk("t3_waited", n > 0, 1);
    @(posedge clk); #2;
    wr = 0;
    wait_empty("t3_empty");
    chk("t3_drained", wq.size(), 0);

    // 4: byte load, rdata_valid for one cycle
    mem[32'h3E8 >> 2] = 32'hA1B2C3D4;
    load_start(32'h3EB, 0, 32'h000000A1);
    load_wait("t4_load", 1, n);
    chk("t4_valid_1cyc", stall, 1);
    rq.push_back(32'h000000A1);
    load_wait("t4_reload", 0, n);

    // 5: reset during an outstanding write
    hold = 1;
    for (int i = 0; i < 3; i++)
      store(32'h40 + 4*i, 32'h77770000 + i, 1, n);
    n = 0;
    #1;
    while (!mreq && n < 20) begin
      @(posedge clk); #3; n++;
    end
    chk("t5_req_up", mreq, 1);
    #3;
    rst_n = 0;
    #1;
    chk("t5_req_drop", mreq, 0);
    chk("t5_empty", empty, 1);
    chk("t5_count", dut.u_fifo.count_q, 0);
    wq.delete();
    hold = 0;
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1;
    reqcnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #3;
      if (mreq) reqcnt++;
    end
    chk("t5_no_req", reqcnt, 0);
    @(posedge clk); #2;

`ifdef WBUF_LOAD_BYPASS_EN
    // 6: loads bypass non-matching buffered stores
    mem[32'h200 >> 2] = 32'hCAFEF00D;
    hold = 1;
    store(32'h104, 32'h0BADF00D, 1, n);
    store(32'h100, 32'h600DCAFE, 1, n);
    load_start(32'h200, 1, 32'hCAFEF00D);
    hold = 0;
    load_wait("t6_bypass", 0, n);
    chk("t6_bypass_early", rd_wq_size, 1);
    wait_empty("t6_empty");
    hold = 1;
    store(32'h104, 32'h11111111, 1, n);
    store(32'h100, 32'h22222222, 1, n);
    load_start(32'h100, 1, 32'h22222222);
    hold = 0;
    load_wait("t6_match", 0, n);
    chk("t6_match_drain", rd_wq_size, 0);
    wait_empty("t6_empty2");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
